dyt_sram_arb: RTL and testbench
===============================

Name: dyt_sram_arb

Overview:
- Parametrised multi-port SRAM controller/arbiter between N core-side requesters (e.g. instruction fetch, data memory) and one Xilinx block-SRAM port.
- Round-robin arbitration, configurable SRAM read latency, byte write strobes, and a per-port ready pulse on completion.
- Adds multi-channel sharing, wait-state sequencing and byte enables, none of which the plain CPU/SRAM signal bundle has.

Parameters:
- NUM_PORTS, 2, number of requesters (>=1)
- ADDR_W, 32, byte-address width
- DATA_W, 32, data width; multiple of 8
- LATENCY, 1, SRAM cycles per access (>=1)

Ports:
- CLK  input  1  clock; all logic on rising edge
- nRST  input  1  asynchronous, active-low reset
- req_ren  input  NUM_PORTS  per-port read request
- req_wen  input  NUM_PORTS  per-port write request
- req_addr  input  NUM_PORTS*ADDR_W  flattened byte addresses; port i at [i*ADDR_W +: ADDR_W]
- req_wdata  input  NUM_PORTS*DATA_W  flattened write data
- req_strb  input  NUM_PORTS*DATA_W/8  flattened byte write enables
- req_rdata  output  DATA_W  read data, shared by all ports; valid when that port's req_ready is high
- req_ready  output  NUM_PORTS  one-cycle completion pulse, one-hot
- sram_address  output  ADDR_W  SRAM address
- sram_w_data  output  DATA_W  SRAM write data
- sram_be  output  DATA_W/8  SRAM byte enables
- sram_ren  output  1  SRAM read strobe
- sram_wen  output  1  SRAM write strobe
- sram_r_data  input  DATA_W  SRAM read data

Behaviour:
- Reset (nRST low, asynchronous): state=IDLE; rr pointer=0; all outputs 0; req_rdata=0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, some port has ren|wen:
  - Grant the first requesting port at or after the rr pointer, wrapping modulo NUM_PORTS.
  - Register that port's addr, wdata and strb into the sram_* outputs, plus op (write if wen, else read).
  - Load wait counter = LATENCY-1; go to ACCESS.
  - rr pointer = grant+1, wrapping to 0 after NUM_PORTS-1.
- ACCESS:
  - sram_ren or sram_wen held high, never both.
  - sram_be = registered strb for writes, all ones for reads.
  - Counter decrements each cycle; at 0, reads capture sram_r_data into req_rdata; go to DONE.
- DONE:
  - req_ready[grant]=1 for exactly this cycle; sram strobes low; go to IDLE.
  - A new grant is possible on the following cycle.
- Latency: request seen in cycle 0 -> req_ready in cycle LATENCY+1, i.e. LATENCY+2 cycles per access; no pipelining.
- Requesters hold ren/wen/addr/wdata stable until their ready pulse.
- Inputs are sampled only in IDLE; changes in ACCESS/DONE are ignored.
- A request withdrawn mid-access still completes, and ready still pulses.
- ren and wen both high on one port: treated as a write.
- req_rdata holds its last read value until the next read completes; writes do not change it.
- Simultaneous requests: exactly one grant per transaction; with all ports continuously requesting, service order is 0,1,...,N-1,0,...
- NUM_PORTS=1: the rr pointer stays 0.
- Reset asserted mid-ACCESS: strobes drop immediately; the transaction is abandoned with no ready pulse.

Optional Feature:
- Macro: DYT_SRAM_MISALIGN_CHK_EN.
- Enabled:
  - Extra output req_err (NUM_PORTS, reset 0).
  - A granted request whose address has any of the low log2(DATA_W/8) bits set skips ACCESS: IDLE -> DONE, no SRAM strobe.
  - DONE pulses req_ready and req_err together for the granted port; req_rdata is unchanged.
- Disabled: no req_err port; the low address bits are forced to 0 on sram_address and the access proceeds normally.

Test Plan:
- Reset: hold nRST=0, drive requests -> all outputs 0, no sram strobes; release -> first grant goes to port 0.
- Single read, LATENCY=1: port0 ren, addr 0x10, SRAM returns 0xDEADBEEF -> sram_ren high 1 cycle, req_ready=2'b01 at cycle 2, req_rdata=0xDEADBEEF.
- Byte write, LATENCY=3: port1 wen, addr 0x20, wdata 0x11223344, strb 4'b0100 -> sram_wen high 3 cycles, sram_be=4'b0100, req_ready=2'b10 at cycle 4.
- Contention: both ports request continuously -> grant order 0,1,0,1; each ready pulse one-hot; back-to-back ready pulses LATENCY+2 cycles apart.
- Async reset mid-ACCESS (LATENCY=4, assert nRST in the 2nd access cycle) -> sram_ren low immediately without a clock edge, no ready, state IDLE after release.
- DYT_SRAM_MISALIGN_CHK_EN: port0 ren, addr 0x13 -> no sram_ren, req_ready[0] and req_err[0] high at cycle 1; without the macro, sram_address=0x10.

Source files
------------

// File: rtl/dyt_sram_arb.sv
// dyt_sram_arb: round-robin arbiter sharing one block-SRAM port among
// NUM_PORTS requesters, with LATENCY wait cycles per access, byte write
// enables and a one-cycle per-port ready pulse on completion.
// Optional: define DYT_SRAM_MISALIGN_CHK_EN to add req_err and reject
// misaligned addresses instead of silently aligning them.
module dyt_sram_arb #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LATENCY   = 1
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic [NUM_PORTS-1:0]          req_ren,
    input  logic [NUM_PORTS-1:0]          req_wen,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    input  logic [NUM_PORTS*DATA_W/8-1:0] req_strb,
    output logic [DATA_W-1:0]             req_rdata,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic [ADDR_W-1:0]             sram_address,
    output logic [DATA_W-1:0]             sram_w_data,
    output logic [DATA_W/8-1:0]           sram_be,
    output logic                          sram_ren,
    output logic                          sram_wen,
    input  logic [DATA_W-1:0]             sram_r_data
`ifdef DYT_SRAM_MISALIGN_CHK_EN
    ,
    output logic [NUM_PORTS-1:0]          req_err
`endif
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // Byte-offset bits of an address within one data word
    localparam logic [ADDR_W-1:0] LSB_MASK = ADDR_W'(STRB_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_q, rr_d;
    logic [PTR_W-1:0]    grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
`ifdef DYT_SRAM_MISALIGN_CHK_EN
    logic                err_q, err_d;
`endif

    logic                any_req;
    logic [PTR_W-1:0]    sel;
    logic                sel_wen;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [STRB_W-1:0]   sel_strb;

    // Round-robin pick: first requester at/after rr_q, then wrap from port 0
    always_comb begin
        any_req = 1'b0;
        sel     = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!any_req && (i >= 32'(rr_q)) && (req_ren[i] || req_wen[i])) begin
                any_req = 1'b1;
                sel     = PTR_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!any_req && (req_ren[i] || req_wen[i])) begin
                any_req = 1'b1;
                sel     = PTR_W'(i);
            end
        end
    end

    // Mux out the selected port's request fields
    always_comb begin
        sel_wen   = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_strb  = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (PTR_W'(i) == sel) begin
                sel_wen   = req_wen[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_strb  = req_strb[i*STRB_W +: STRB_W];
            end
        end
    end

    // Next-state logic: grant in IDLE, count wait states in ACCESS
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
`ifdef DYT_SRAM_MISALIGN_CHK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = sel;
                    rr_d    = (32'(sel) == NUM_PORTS - 1) ? '0 : sel + 1'b1;
                    op_wr_d = sel_wen;
                    addr_d  = sel_addr & ~LSB_MASK;
                    wdata_d = sel_wdata;
                    be_d    = sel_wen ? sel_strb : '1;
                    cnt_d   = CNT_W'(LATENCY - 1);
`ifdef DYT_SRAM_MISALIGN_CHK_EN
                    err_d   = |(sel_addr & LSB_MASK);
                    state_d = (|(sel_addr & LSB_MASK)) ? DONE : ACCESS;
`else
                    state_d = ACCESS;
`endif
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!op_wr_q) begin
                        rdata_d = sram_r_data;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
`ifdef DYT_SRAM_MISALIGN_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
`ifdef DYT_SRAM_MISALIGN_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign sram_address = addr_q;
    assign sram_w_data  = wdata_q;
    assign sram_be      = be_q;
    assign req_rdata    = rdata_q;
    // Strobes decode from state so an async reset drops them at once
    assign sram_ren     = (state_q == ACCESS) && !op_wr_q;
    assign sram_wen     = (state_q == ACCESS) && op_wr_q;

    // One-hot completion pulse for the granted port while in DONE
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if ((state_q == DONE) && (PTR_W'(i) == grant_q)) begin
                req_ready[i] = 1'b1;
            end
        end
    end

`ifdef DYT_SRAM_MISALIGN_CHK_EN
    // Error pulse accompanies ready for a rejected misaligned request
    always_comb begin
        req_err = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if ((state_q == DONE) && err_q && (PTR_W'(i) == grant_q)) begin
                req_err[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dyt_sram_arb.sv
// Directed testbench for dyt_sram_arb: three instances (LATENCY 1, 3, 4)
// share one stimulus bus; each test resets all and checks one instance.
module tb_dyt_sram_arb;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  req_ren;
    logic [1:0]  req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_strb;
    logic [31:0] sram_r_data;

    logic [31:0] l1_rdata, l3_rdata, l4_rdata;
    logic [1:0]  l1_ready, l3_ready, l4_ready;
    logic [31:0] l1_addr, l3_addr, l4_addr;
    logic [31:0] l1_wd, l3_wd, l4_wd;
    logic [3:0]  l1_be, l3_be, l4_be;
    logic        l1_ren, l3_ren, l4_ren;
    logic        l1_wen, l3_wen, l4_wen;
`ifdef DYT_SRAM_MISALIGN_CHK_EN
    logic [1:0]  l1_err, l3_err, l4_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    dyt_sram_arb #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_l1 (
        .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_rdata(l1_rdata), .req_ready(l1_ready), .sram_address(l1_addr),
        .sram_w_data(l1_wd), .sram_be(l1_be), .sram_ren(l1_ren),
        .sram_wen(l1_wen), .sram_r_data(sram_r_data)
`ifdef DYT_SRAM_MISALIGN_CHK_EN
        , .req_err(l1_err)
`endif
    );

    dyt_sram_arb #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .LATENCY(3)) u_l3 (
        .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_rdata(l3_rdata), .req_ready(l3_ready), .sram_address(l3_addr),
        .sram_w_data(l3_wd), .sram_be(l3_be), .sram_ren(l3_ren),
        .sram_wen(l3_wen), .sram_r_data(sram_r_data)
`ifdef DYT_SRAM_MISALIGN_CHK_EN
        , .req_err(l3_err)
`endif
    );

    dyt_sram_arb #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .LATENCY(4)) u_l4 (
        .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_rdata(l4_rdata), .req_ready(l4_ready), .sram_address(l4_addr),
        .sram_w_data(l4_wd), .sram_be(l4_be), .sram_ren(l4_ren),
        .sram_wen(l4_wen), .sram_r_data(sram_r_data)
`ifdef DYT_SRAM_MISALIGN_CHK_EN
        , .req_err(l4_err)
`endif
    );

    typedef struct {
        int          port;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rd;
        logic        exp_wr;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr_req();
        req_ren   = '0;
        req_wen   = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
    endtask

    task automatic set_req(input int p, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_ren[p]            = r;
        req_wen[p]            = w;
        req_addr[p*32 +: 32]  = a;
        req_wdata[p*32 +: 32] = d;
        req_strb[p*4 +: 4]    = s;
    endtask

    // Leaves time at posedge+1 with reset released: the caller's "cycle 0"
    task automatic do_reset();
        nRST = 1'b0;
        clr_req();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_rdy;

        vecs[0] = '{0, 1'b1, 1'b0, 32'h10,       32'h0,        4'h0,    32'hDEADBEEF, 1'b0, 4'hF,    32'h10,       32'hDEADBEEF};
        vecs[1] = '{1, 1'b0, 1'b1, 32'h20,       32'h11223344, 4'b0100, 32'h0,        1'b1, 4'b0100, 32'h20,       32'hDEADBEEF};
        vecs[2] = '{1, 1'b1, 1'b0, 32'h44,       32'h0,        4'h0,    32'hCAFEF00D, 1'b0, 4'hF,    32'h44,       32'hCAFEF00D};
        vecs[3] = '{0, 1'b1, 1'b1, 32'h08,       32'hA5A5A5A5, 4'b1001, 32'h55555555, 1'b1, 4'b1001, 32'h08,       32'hCAFEF00D};
        vecs[4] = '{0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        4'h0,    32'h0BADF00D, 1'b0, 4'hF,    32'hFFFFFFFC, 32'h0BADF00D};

        // Reset held with requests pending: everything stays zero
        nRST = 1'b0;
        sram_r_data = 32'h12121212;
        clr_req();
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("rst_ready", {30'b0, l1_ready}, 32'h0);
            chk("rst_strobes", {30'b0, l1_ren, l1_wen}, 32'h0);
            chk("rst_addr", l1_addr, 32'h0);
            chk("rst_be", {28'b0, l1_be}, 32'h0);
            chk("rst_rdata", l1_rdata, 32'h0);
        end
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("first_grant_addr", l1_addr, 32'h10);
        @(negedge CLK);
        chk("first_grant_ready", {30'b0, l1_ready}, 32'h1);
        chk("first_grant_rdata", l1_rdata, 32'h12121212);

        // Table of single transactions on the LATENCY=1 instance
        do_reset();
        for (int v = 0; v < 5; v++) begin
            set_req(vecs[v].port, vecs[v].ren, vecs[v].wen, vecs[v].addr, vecs[v].wdata, vecs[v].strb);
            sram_r_data = vecs[v].rd;
            @(negedge CLK);
            chk($sformatf("v%0d_c0_strobes", v), {30'b0, l1_ren, l1_wen}, 32'h0);
            chk($sformatf("v%0d_c0_ready", v), {30'b0, l1_ready}, 32'h0);
            @(negedge CLK);
            chk($sformatf("v%0d_ren", v), {31'b0, l1_ren}, {31'b0, ~vecs[v].exp_wr});
            chk($sformatf("v%0d_wen", v), {31'b0, l1_wen}, {31'b0, vecs[v].exp_wr});
            chk($sformatf("v%0d_be", v), {28'b0, l1_be}, {28'b0, vecs[v].exp_be});
            chk($sformatf("v%0d_addr", v), l1_addr, vecs[v].exp_addr);
            if (vecs[v].exp_wr) chk($sformatf("v%0d_wdata", v), l1_wd, vecs[v].wdata);
            chk($sformatf("v%0d_c1_ready", v), {30'b0, l1_ready}, 32'h0);
            @(negedge CLK);
            exp_rdy = 2'b01 << vecs[v].port;
            chk($sformatf("v%0d_ready", v), {30'b0, l1_ready}, {30'b0, exp_rdy});
            chk($sformatf("v%0d_rdata", v), l1_rdata, vecs[v].exp_rdata);
            chk($sformatf("v%0d_done_strobes", v), {30'b0, l1_ren, l1_wen}, 32'h0);
            clr_req();
            @(negedge CLK);
            chk($sformatf("v%0d_c3_ready", v), {30'b0, l1_ready}, 32'h0);
            @(posedge CLK);
            #1;
        end

        // Contention, LATENCY=1: order 0,1,0,1, pulses three cycles apart
        do_reset();
        sram_r_data = 32'h0;
        set_req(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
        for (int c = 0; c < 13; c++) begin
            @(negedge CLK);
            if (c >= 2 && (c - 2) % 3 == 0) exp_rdy = (((c - 2) / 3) % 2 == 0) ? 2'b01 : 2'b10;
            else exp_rdy = 2'b00;
            chk($sformatf("cont_ready_c%0d", c), {30'b0, l1_ready}, {30'b0, exp_rdy});
            if (c >= 1 && (c - 1) % 3 == 0)
                chk($sformatf("cont_addr_c%0d", c), l1_addr, ((((c - 1) / 3) % 2) == 0) ? 32'h100 : 32'h200);
        end
        clr_req();

        // Byte write on the LATENCY=3 instance
        do_reset();
        set_req(1, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'b0100);
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            chk($sformatf("l3_wen_c%0d", c), {31'b0, l3_wen}, {31'b0, (c >= 1 && c <= 3)});
            chk($sformatf("l3_ren_c%0d", c), {31'b0, l3_ren}, 32'h0);
            chk($sformatf("l3_ready_c%0d", c), {30'b0, l3_ready}, (c == 4) ? 32'h2 : 32'h0);
            if (c == 1) begin
                chk("l3_be", {28'b0, l3_be}, 32'h4);
                chk("l3_wdata", l3_wd, 32'h11223344);
                chk("l3_addr", l3_addr, 32'h20);
            end
            if (c == 4) clr_req();
        end

        // Async reset in the second ACCESS cycle on the LATENCY=4 instance
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
        @(negedge CLK);
        @(negedge CLK);
        chk("l4_ren_c1", {31'b0, l4_ren}, 32'h1);
        @(posedge CLK);
        #2;
        chk("l4_ren_c2", {31'b0, l4_ren}, 32'h1);
        nRST = 1'b0;
        #1;
        chk("l4_ren_async_drop", {31'b0, l4_ren}, 32'h0);
        clr_req();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            chk($sformatf("l4_no_ready_c%0d", c), {30'b0, l4_ready}, 32'h0);
        end
        @(posedge CLK);
        #1;
        set_req(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        sram_r_data = 32'h00000077;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            chk($sformatf("l4_after_ready_c%0d", c), {30'b0, l4_ready}, (c == 5) ? 32'h2 : 32'h0);
            if (c == 5) begin
                chk("l4_after_rdata", l4_rdata, 32'h00000077);
                clr_req();
            end
        end

        // Misaligned address handling
        do_reset();
        sram_r_data = 32'h12345678;
        set_req(0, 1'b1, 1'b0, 32'h13, 32'h0, 4'h0);
        @(negedge CLK);
        @(negedge CLK);
`ifdef DYT_SRAM_MISALIGN_CHK_EN
        chk("mis_ren", {31'b0, l1_ren}, 32'h0);
        chk("mis_ready", {30'b0, l1_ready}, 32'h1);
        chk("mis_err", {30'b0, l1_err}, 32'h1);
        chk("mis_rdata", l1_rdata, 32'h0);
        clr_req();
        @(negedge CLK);
        chk("mis_err_clear", {30'b0, l1_err}, 32'h0);
        chk("mis_ready_clear", {30'b0, l1_ready}, 32'h0);
`else
        chk("mis_addr_aligned", l1_addr, 32'h10);
        chk("mis_ren", {31'b0, l1_ren}, 32'h1);
        @(negedge CLK);
        chk("mis_ready", {30'b0, l1_ready}, 32'h1);
        chk("mis_rdata", l1_rdata, 32'h12345678);
        clr_req();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
